// File: rtl/qdec_ctx_store.sv
// qdec_ctx_store: CABAC context table with self-timed INIT/SAVE/RESTORE sweeps; decoder reads return 1 cycle after ctx_re.
// No backpressure: an accepted command holds busy for NUM_CTX+1 cycles, and decoder traffic and new commands are ignored meanwhile.
module qdec_ctx_store #(
    parameter int ADDR_W     = 10,
    parameter int NUM_CTX    = 1024,
    parameter int SAVE_SLOTS = 2,
    parameter int SLOT_W     = (SAVE_SLOTS > 1) ? $clog2(SAVE_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ctx_addr,
    input  logic              ctx_re,
    input  logic              ctx_we,
    input  logic [7:0]        ctx_wdata,
    output logic [7:0]        ctx_rdata,
    output logic              ctx_rvalid,
    input  logic              cmd_start,
    input  logic [1:0]        cmd_op,
    input  logic [SLOT_W-1:0] cmd_slot,
    input  logic [6:0]        slice_qp,
    output logic [ADDR_W-1:0] init_rom_addr,
    output logic              init_rom_re,
    input  logic [7:0]        init_rom_data,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int SNAP_N = SAVE_SLOTS * NUM_CTX;
    localparam int SNAP_W = (SNAP_N > 1) ? $clog2(SNAP_N) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CTX - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_SAVE, ST_RESTORE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   iss_idx;
    logic [ADDR_W-1:0]   wr_idx;
    logic                iss_act;
    logic                wr_act;
    logic [6:0]          qp_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [7:0]          src_q;
    logic [7:0]          work_mem [NUM_CTX];
    logic [7:0]          snap_mem [SNAP_N];

    logic                is_idle;
    logic                addr_ok;
    logic                slot_ok;
    logic                cmd_ok;
    logic [SNAP_W-1:0]   snap_rd_addr;
    logic [SNAP_W-1:0]   snap_wr_addr;
    logic [7:0]          wr_dat;

    // Context init from (slope, offset) nibbles; intermediates are 16-bit signed.
    function automatic logic [7:0] init_entry(input logic [7:0] iv, input logic [6:0] qp);
        logic signed [15:0] m;
        logic signed [15:0] n;
        logic signed [15:0] q;
        logic signed [15:0] pre;
        m = $signed({12'd0, iv[7:4]}) * 16'sd5 - 16'sd45;
        n = $signed({9'd0, iv[3:0], 3'd0}) - 16'sd16;
        if (qp[6])
            q = 16'sd0;
        else if (qp > 7'd51)
            q = 16'sd51;
        else
            q = $signed({9'd0, qp});
        pre = ((m * q) >>> 4) + n;
        if (pre < 16'sd1)
            pre = 16'sd1;
        else if (pre > 16'sd126)
            pre = 16'sd126;
        if (pre > 16'sd63)
            return {1'b0, 6'(pre - 16'sd64), 1'b1};
        return {1'b0, 6'(16'sd63 - pre), 1'b0};
    endfunction

    assign is_idle      = (state == ST_IDLE);
    assign addr_ok      = int'(ctx_addr) < NUM_CTX;
    assign slot_ok      = int'(cmd_slot) < SAVE_SLOTS;
    assign cmd_ok       = cmd_start && is_idle &&
                          ((cmd_op == 2'd0) || ((cmd_op == 2'd1 || cmd_op == 2'd2) && slot_ok));
    assign snap_rd_addr = SNAP_W'(slot_q) * SNAP_W'(NUM_CTX) + SNAP_W'(iss_idx);
    assign snap_wr_addr = SNAP_W'(slot_q) * SNAP_W'(NUM_CTX) + SNAP_W'(wr_idx);
    assign wr_dat       = (state == ST_INIT) ? init_entry(init_rom_data, qp_q) : src_q;

    // Table storage: stage 1 reads the source into src_q, stage 2 writes the destination.
    always_ff @(posedge clk) begin
        if (is_idle && ctx_we && addr_ok)
            work_mem[IDX_W'(ctx_addr)] <= ctx_wdata;
        else if (wr_act && (state == ST_INIT || state == ST_RESTORE))
            work_mem[IDX_W'(wr_idx)] <= wr_dat;
        if (wr_act && state == ST_SAVE)
            snap_mem[snap_wr_addr] <= src_q;
        if (iss_act)
            src_q <= (state == ST_RESTORE) ? snap_mem[snap_rd_addr] : work_mem[IDX_W'(iss_idx)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            iss_idx       <= '0;
            wr_idx        <= '0;
            iss_act       <= 1'b0;
            wr_act        <= 1'b0;
            qp_q          <= '0;
            slot_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            init_rom_addr <= '0;
            init_rom_re   <= 1'b0;
            ctx_rdata     <= '0;
            ctx_rvalid    <= 1'b0;
        end else begin
            done       <= 1'b0;
            ctx_rvalid <= is_idle && ctx_re;
            if (is_idle && ctx_re) begin
                if (!addr_ok)
                    ctx_rdata <= 8'h00;
                else if (ctx_we)
                    ctx_rdata <= ctx_wdata;
                else
                    ctx_rdata <= work_mem[IDX_W'(ctx_addr)];
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_ok) begin
                        case (cmd_op)
                            2'd0:    state <= ST_INIT;
                            2'd1:    state <= ST_SAVE;
                            default: state <= ST_RESTORE;
                        endcase
                        qp_q          <= slice_qp;
                        slot_q        <= cmd_slot;
                        iss_idx       <= '0;
                        iss_act       <= 1'b1;
                        busy          <= 1'b1;
                        init_rom_re   <= (cmd_op == 2'd0);
                        init_rom_addr <= '0;
                    end
                end
                default: begin
                    wr_act <= iss_act;
                    wr_idx <= iss_idx;
                    if (iss_act) begin
                        if (iss_idx == LAST_IDX) begin
                            iss_act       <= 1'b0;
                            done          <= 1'b1;
                            init_rom_re   <= 1'b0;
                            init_rom_addr <= '0;
                        end else begin
                            iss_idx       <= iss_idx + ADDR_W'(1);
                            init_rom_addr <= (state == ST_INIT) ? iss_idx + ADDR_W'(1) : '0;
                        end
                    end else begin
                        // Final write cycle: done is already high, drop busy and go idle.
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        wr_act <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
